// File: rtl/q15_pkg.sv
// Shared Q16.48 fixed-point definitions for the intersection datapath.
// Special codes are shared by the multiplier and every saturating adder.
package q15_pkg;

    localparam int Q15_W    = 64;
    localparam int Q15_FRAC = 48;

    localparam logic [Q15_W-1:0] Q15_POS_INF = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [Q15_W-1:0] Q15_NEG_INF = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [Q15_W-1:0] Q15_NAN     = 64'h8000_0000_0000_0000;
    localparam logic [Q15_W-1:0] Q15_ONE     = 64'h0001_0000_0000_0000;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        DONE
    } q15_state_t;

endpackage

// File: rtl/q15_multiplier.sv
// Combinational Q16.48 multiplier with Inf/NaN handling and saturation.
// The fractional result is truncated toward minus infinity (arithmetic shift).
module q15_multiplier
    import q15_pkg::*;
(
    input  logic [Q15_W-1:0] a,
    input  logic [Q15_W-1:0] b,
    output logic [Q15_W-1:0] p
);

    // Largest finite code and the NaN code, sign-extended to full product width.
    localparam logic signed [2*Q15_W-1:0] P_MAX = 128'sh0000_0000_0000_0000_7FFF_FFFF_FFFF_FFFE;
    localparam logic signed [2*Q15_W-1:0] P_MIN = 128'shFFFF_FFFF_FFFF_FFFF_8000_0000_0000_0000;

    logic signed [2*Q15_W-1:0] ae, be, full, shf;
    logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;

    assign ae   = {{Q15_W{a[Q15_W-1]}}, a};
    assign be   = {{Q15_W{b[Q15_W-1]}}, b};
    assign full = ae * be;
    assign shf  = full >>> Q15_FRAC;

    assign a_nan  = (a == Q15_NAN);
    assign b_nan  = (b == Q15_NAN);
    assign a_inf  = (a == Q15_POS_INF) || (a == Q15_NEG_INF);
    assign b_inf  = (b == Q15_POS_INF) || (b == Q15_NEG_INF);
    assign a_zero = (a == '0);
    assign b_zero = (b == '0);

    // Special operands first, then saturate the finite product into the
    // finite range. +Inf/-Inf carry msb 0/1, so the product sign is a^b msb.
    always_comb begin
        p = shf[Q15_W-1:0];
        if (a_nan || b_nan) begin
            p = Q15_NAN;
        end else if (a_inf || b_inf) begin
            if (a_zero || b_zero)
                p = Q15_NAN;
            else
                p = (a[Q15_W-1] ^ b[Q15_W-1]) ? Q15_NEG_INF : Q15_POS_INF;
        end else if (shf > P_MAX) begin
            p = Q15_POS_INF;
        end else if ((shf <= P_MIN) || (shf == '1)) begin
            // -1 ulp shares its bit pattern with -Inf
            p = Q15_NEG_INF;
        end
    end

endmodule

// File: rtl/q15_sat_add.sv
// Combinational saturating Q16.48 adder with Inf/NaN propagation.
// Kept standalone so other accumulators can reuse the same rules.
module q15_sat_add
    import q15_pkg::*;
(
    input  logic [Q15_W-1:0] x,
    input  logic [Q15_W-1:0] y,
    output logic [Q15_W-1:0] s
);

    localparam logic signed [Q15_W:0] S_MAX = 65'sh0_7FFF_FFFF_FFFF_FFFE;
    localparam logic signed [Q15_W:0] S_MIN = 65'sh1_8000_0000_0000_0000;

    logic signed [Q15_W:0] sum;
    logic x_nan, y_nan, x_pinf, y_pinf, x_ninf, y_ninf;

    assign sum    = $signed({x[Q15_W-1], x}) + $signed({y[Q15_W-1], y});
    assign x_nan  = (x == Q15_NAN);
    assign y_nan  = (y == Q15_NAN);
    assign x_pinf = (x == Q15_POS_INF);
    assign y_pinf = (y == Q15_POS_INF);
    assign x_ninf = (x == Q15_NEG_INF);
    assign y_ninf = (y == Q15_NEG_INF);

    // Priority: NaN, opposing infinities, infinities, then saturated sum.
    always_comb begin
        s = sum[Q15_W-1:0];
        if (x_nan || y_nan)
            s = Q15_NAN;
        else if ((x_pinf && y_ninf) || (x_ninf && y_pinf))
            s = Q15_NAN;
        else if (x_pinf || y_pinf)
            s = Q15_POS_INF;
        else if (x_ninf || y_ninf)
            s = Q15_NEG_INF;
        else if (sum > S_MAX)
            s = Q15_POS_INF;
        else if ((sum <= S_MIN) || (sum == '1))
            s = Q15_NEG_INF;
    end

endmodule

// File: rtl/q15_dot3_acc.sv
// Sequential Q16.48 dot product: one shared multiplier, one term per cycle,
// saturating accumulation, result held until the consumer takes it.
module q15_dot3_acc
    import q15_pkg::*;
#(
    parameter int N_TERMS = 3,
    parameter int W       = Q15_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N_TERMS*W-1:0] a_vec,
    input  logic [N_TERMS*W-1:0] b_vec,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [W-1:0]         res
);

    localparam int IDX_W = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_TERMS - 1);

    q15_state_t state, state_nxt;

    logic [N_TERMS-1:0][W-1:0] a_r, b_r;
    logic [W-1:0]              acc, acc_nxt, prod, res_r;
    logic [IDX_W-1:0]          idx;
    logic                      accept, last;

    assign accept = in_valid && in_ready;
    assign last   = (idx == LAST_IDX);
    assign res    = res_r;

    q15_multiplier u_mul (
        .a (a_r[idx]),
        .b (b_r[idx]),
        .p (prod)
    );

    q15_sat_add u_add (
        .x (acc),
        .y (prod),
        .s (acc_nxt)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next state and handshake outputs; DONE keeps in_ready low so a new
    // accept can never coincide with the result hand-off.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid)
                    state_nxt = MAC;
            end
            MAC: begin
                if (last)
                    state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture, per-term accumulation and result register.
    // No early exit on specials: always exactly N_TERMS MAC cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r   <= '0;
            b_r   <= '0;
            acc   <= '0;
            idx   <= '0;
            res_r <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_r <= a_vec;
                        b_r <= b_vec;
                        acc <= '0;
                        idx <= '0;
                    end
                end
                MAC: begin
                    acc <= acc_nxt;
                    idx <= last ? '0 : idx + IDX_W'(1);
                    if (last)
                        res_r <= acc_nxt;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_q15_dot3_acc.sv
// Self-checking bench for q15_dot3_acc: vector table through a scoreboard,
// plus backpressure and reset-abort sequences.
module tb_q15_dot3_acc;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [191:0]   a_vec;
    logic [191:0]   b_vec;
    logic           out_valid;
    logic           out_ready;
    logic [63:0]    res;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [2:0][63:0] a;
        logic [2:0][63:0] b;
        logic [63:0]      exp;
        string            name;
    } vec_t;

    vec_t        vt[10];
    logic [63:0] sb[$];

    q15_dot3_acc #(.N_TERMS(3), .W(64)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_vec     (a_vec),
        .b_vec     (b_vec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res       (res)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] q(input int v);
        longint x;
        x = v;
        return 64'(x <<< 48);
    endfunction

    function automatic vec_t mk(input logic [63:0] a0, a1, a2, b0, b1, b2, e,
                                input string n);
        vec_t t;
        t.a    = {a2, a1, a0};
        t.b    = {b2, b1, b0};
        t.exp  = e;
        t.name = n;
        return t;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Caller is positioned at a negedge. Drives vector i, waits for accept,
    // checks latency, holds out_ready low for 'hold' cycles (optionally
    // presenting vector 'pre' on the input meanwhile), then takes the result.
    task automatic run_op(input int i, input int hold, input int pre);
        int          n;
        logic [63:0] e;
        a_vec    = vt[i].a;
        b_vec    = vt[i].b;
        in_valid = 1'b1;
        sb.push_back(vt[i].exp);
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({vt[i].name, " accept"}, 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({vt[i].name, " latency"}, 64'(n), 64'd3);
        e = sb.pop_front();
        for (int h = 0; h < hold; h++) begin
            if (pre >= 0) begin
                a_vec    = vt[pre].a;
                b_vec    = vt[pre].b;
                in_valid = 1'b1;
            end
            @(negedge clk);
            check({vt[i].name, " hold res"}, res, e);
            check({vt[i].name, " hold vld/rdy"}, {62'd0, out_valid, in_ready}, 64'b10);
        end
        out_ready = 1'b1;
        check({vt[i].name, " res"}, res, e);
        @(negedge clk);
        out_ready = 1'b0;
        check({vt[i].name, " back to idle"}, {62'd0, out_valid, in_ready}, 64'b01);
    endtask

    initial begin
        vt[0] = mk(q(1), q(2), q(3), q(4), q(5), q(6), 64'h0020_0000_0000_0000, "dot123");
        vt[1] = mk(64'h0001_2000_0000_0000, 0, 0, q(-8), 0, 0, 64'hFFF7_0000_0000_0000, "frac");
        vt[2] = mk(q(32767), q(32767), 0, q(2), q(2), 0, 64'h7FFF_FFFF_FFFF_FFFF, "ovf");
        vt[3] = mk(q(2), q(2), 0, q(32767), 64'h8000_0000_0000_0001, 0,
                   64'h8000_0000_0000_0000, "infcancel");
        vt[4] = mk(q(-32767), q(-32767), 0, q(2), q(2), 0, 64'hFFFF_FFFF_FFFF_FFFF, "negsat");
        vt[5] = mk(64'h7FFF_FFFF_FFFF_FFFE, 0, 0, q(1), 0, 0, 64'h7FFF_FFFF_FFFF_FFFE, "maxfin");
        vt[6] = mk(64'h7FFF_FFFF_FFFF_FFFE, 64'h1, 0, q(1), q(1), 0,
                   64'h7FFF_FFFF_FFFF_FFFF, "maxfin+1");
        vt[7] = mk(q(1), q(-1), 0, q(1), 64'h0001_0000_0000_0001, 0,
                   64'hFFFF_FFFF_FFFF_FFFF, "negulp");
        vt[8] = mk(64'h8000_0000_0000_0000, q(1), q(2), q(1), q(3), q(4),
                   64'h8000_0000_0000_0000, "nanprop");
        vt[9] = mk(q(-3), q(5), q(-2), q(7), q(-1), q(-4), 64'hFFEE_0000_0000_0000, "mixed");

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a_vec     = '0;
        b_vec     = '0;
        #3;
        check("reset in_ready", 64'(in_ready), 64'd1);
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset res", res, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++)
            run_op(i, 0, -1);

        // Backpressure with a new request waiting; it must be taken only
        // after the held result is consumed.
        run_op(0, 5, 9);
        run_op(9, 0, -1);

        // Reset while the second term is being accumulated.
        a_vec    = vt[0].a;
        b_vec    = vt[0].b;
        in_valid = 1'b1;
        begin
            int n;
            n = 0;
            while (!in_ready && n < 50) begin
                @(negedge clk);
                n++;
            end
            check("abort accept", 64'(in_ready), 64'd1);
        end
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort in_ready", 64'(in_ready), 64'd1);
        check("abort out_valid", 64'(out_valid), 64'd0);
        check("abort res", res, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("abort no pulse", {62'd0, out_valid, in_ready}, 64'b01);
        end
        run_op(0, 0, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
